// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - config write port of clock_divider_bank (cfg_duty only with CLKDIV_DUTY_EN)
interface clock_divider_bank_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [CNT_W-1:0] cfg_div;
`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0] cfg_duty;

    modport master (output cfg_valid, output cfg_chan, output cfg_div, output cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_chan, input cfg_div, input cfg_duty, output cfg_ready);
`else
    modport master (output cfg_valid, output cfg_chan, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_chan, input cfg_div, output cfg_ready);
`endif
endinterface

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of glitch-free integer clock dividers; CLKDIV_DUTY_EN adds programmable high time
module clock_divider_bank #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1133,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    clock_divider_bank_if.slave cfg,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_HI  = DEF_DIV >> 1;

    logic [CNT_W-1:0]    cnt  [CHANNELS];
    logic [CNT_W-1:0]    div  [CHANNELS];
    logic [CNT_W-1:0]    hi   [CHANNELS];
    logic [CNT_W-1:0]    sdiv [CHANNELS];
    logic [CNT_W-1:0]    shi  [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] last;
    logic [31:0]         chan_idx;
    logic                pend_sel;
    logic                accept;
    logic [CNT_W-1:0]    new_div;
    logic [CNT_W-1:0]    new_hi;

    assign chan_idx = 32'(cfg.cfg_chan);

    // Out-of-range channels never match, so they always read ready and are dropped.
    always_comb begin
        pend_sel = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_idx == 32'(i)) pend_sel = pending[i];
        end
    end

    assign cfg.cfg_ready = !pend_sel;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        new_div = (cfg.cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg.cfg_div;
`ifdef CLKDIV_DUTY_EN
        if (cfg.cfg_duty == '0)
            new_hi = CNT_W'(1);
        else if (cfg.cfg_duty > new_div - CNT_W'(1))
            new_hi = new_div - CNT_W'(1);
        else
            new_hi = cfg.cfg_duty;
`else
        new_hi = new_div >> 1;
`endif
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i] = (cnt[i] >= div[i] - CNT_W'(1));
            last[i] = (cnt[i] == div[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]  <= '0;
                div[i]  <= DEF_DIV;
                hi[i]   <= DEF_HI;
                sdiv[i] <= DEF_DIV;
                shi[i]  <= DEF_HI;
            end
            pending <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (enable[i]) begin
                    cnt[i]     <= wrap[i] ? '0 : cnt[i] + CNT_W'(1);
                    clk_out[i] <= (cnt[i] < hi[i]);
                    tick[i]    <= last[i];
                end else begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end
                // Shadow values only move to the active set at a period boundary.
                if (pending[i] && (!enable[i] || wrap[i])) begin
                    div[i]     <= sdiv[i];
                    hi[i]      <= shi[i];
                    pending[i] <= 1'b0;
                end
                if (accept && chan_idx == 32'(i)) begin
                    sdiv[i]    <= new_div;
                    shi[i]     <= new_hi;
                    pending[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - scoreboard bench for clock_divider_bank against a period-timestamp model
module tb_clock_divider_bank;
    localparam int CH    = 4;
    localparam int CNT_W = 16;
    localparam int CH_W  = 2;
    localparam int DEF   = 1133;

    logic          clk_in = 1'b0;
    logic          reset;
    logic [CH-1:0] enable;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    clock_divider_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

    clock_divider_bank #(.CHANNELS(CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (enable),
        .cfg     (cfg_if.slave),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Stimulus values applied for the upcoming edge.
    bit          rst;
    bit [CH-1:0] en;
    bit          vld;
    int          ch;
    int          d;
    int          du;

    // Model: each channel's current period began at edge m_start (count 0 there).
    longint t = 0;
    longint m_start [CH];
    int     m_div [CH];
    int     m_hi  [CH];
    int     m_sd  [CH];
    int     m_sh  [CH];
    bit     m_pend[CH];

    logic [2*CH-1:0] exp_q[$];

    function automatic bit ready_model(int c);
        if (c >= CH) return 1'b1;
        return !m_pend[c];
    endfunction

    function automatic int hi_rule(int nd, int duty);
`ifdef CLKDIV_DUTY_EN
        if (duty < 1) return 1;
        if (duty > nd - 1) return nd - 1;
        return duty;
`else
        return nd / 2;
`endif
    endfunction

    task automatic model_edge();
        logic [CH-1:0] eo;
        logic [CH-1:0] et;
        longint pos;
        bit rdy;
        int nd;
        eo = '0;
        et = '0;
        rdy = ready_model(ch);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_start[c] = t + 1;
                m_div[c]   = DEF;
                m_hi[c]    = DEF / 2;
                m_pend[c]  = 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (en[c]) begin
                    pos = t - m_start[c];
                    eo[c] = (pos < longint'(m_hi[c]));
                    et[c] = (pos == longint'(m_div[c] - 1));
                    if (pos >= longint'(m_div[c] - 1)) begin
                        m_start[c] = t + 1;
                        if (m_pend[c]) begin
                            m_div[c] = m_sd[c]; m_hi[c] = m_sh[c]; m_pend[c] = 1'b0;
                        end
                    end
                end else begin
                    m_start[c] = t + 1;
                    if (m_pend[c]) begin
                        m_div[c] = m_sd[c]; m_hi[c] = m_sh[c]; m_pend[c] = 1'b0;
                    end
                end
            end
            if (vld && rdy && ch < CH) begin
                nd = (d < 2) ? 2 : d;
                m_pend[ch] = 1'b1;
                m_sd[ch]   = nd;
                m_sh[ch]   = hi_rule(nd, du);
            end
        end
        exp_q.push_back({eo, et});
        t++;
    endtask

    task automatic step();
        bit rdy_exp;
        reset            = rst;
        enable           = en;
        cfg_if.cfg_valid = vld;
        cfg_if.cfg_chan  = CH_W'(ch);
        cfg_if.cfg_div   = CNT_W'(d);
`ifdef CLKDIV_DUTY_EN
        cfg_if.cfg_duty  = CNT_W'(du);
`endif
        #1;
        if (!rst) begin
            rdy_exp = ready_model(ch);
            total++;
            if (cfg_if.cfg_ready !== rdy_exp) begin
                bad++;
                $display("FAIL cfg_ready t=%0d ch=%0d got=%b exp=%b", t, ch, cfg_if.cfg_ready, rdy_exp);
            end
        end
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wr(int c, int dv, int dt);
        vld = 1'b1; ch = c; d = dv; du = dt;
        step();
        vld = 1'b0;
    endtask

    // Monitor: outputs are presented every cycle, one expected entry per edge.
    initial begin
        logic [2*CH-1:0] e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (clk_out !== e[2*CH-1:CH]) begin
                    bad++;
                    $display("FAIL clk_out edge=%0d got=%b exp=%b", t - 1, clk_out, e[2*CH-1:CH]);
                end
                total++;
                if (tick !== e[CH-1:0]) begin
                    bad++;
                    $display("FAIL tick edge=%0d got=%b exp=%b", t - 1, tick, e[CH-1:0]);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; en = '0; vld = 1'b0; ch = 0; d = 0; du = 0;
        run(3);
        rst = 1'b0;

        en = 4'b0001;
        run(2 * DEF + 40);

        en = 4'b0011;
        run(37);
        ch = 1;
        wr(1, 0, 0);
        run(1200);

        en = 4'b0111;
        ch = 2;
        guard = 0;
        while ((t - m_start[2]) != 100 && guard < 3000) begin
            step();
            guard++;
        end
        if (guard >= 3000) begin
            total++; bad++;
            $display("FAIL ch2_wait got=%0d exp=100", t - m_start[2]);
        end
        wr(2, 5, 0);
        vld = 1'b1; ch = 2; d = 7;
        run(20);
        vld = 1'b0;
        run(1100);

        ch = 3;
        wr(3, 10, 5);
        run(3);
        en = 4'b1111;
        run(40);

        ch = 0;
        wr(0, 3, 0);
        run(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(DEF + 30);

`ifdef CLKDIV_DUTY_EN
        wr(0, 8, 0);
        run(DEF + 20);
        wr(0, 8, 20);
        run(40);
`endif

        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 99) == 0) en[c] = ~en[c];
            if ($urandom_range(0, 7) == 0) begin
                vld = 1'b1;
                ch  = $urandom_range(0, CH - 1);
                d   = $urandom_range(0, 24);
                du  = $urandom_range(0, 30);
            end else begin
                vld = 1'b0;
            end
            step();
        end
        vld = 1'b0;
        run(2);

        @(negedge clk_in);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
